// File: rtl/decode_pkg.sv
// Shared opcode constants, the predecoded queue entry and register-usage helpers
// for the decode/issue queue.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Register indices are stored already gated: an unused source reads as x0.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        to_lsb;
    logic        illegal;
  } entry_t;

  function automatic logic is_legal(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opc);
    case (opc)
      OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
      default:                                                       return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_STORE, OPC_BRANCH: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  function automatic logic has_rd(input logic [6:0] opc);
    return !(opc == OPC_STORE || opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/decode_issue_queue_if.sv
// Fetch-side, register-file and issue-side signals of the decode/issue queue.
// slave = the queue itself, master = its surroundings (fetcher, regfile, RoB/RS/LSB).
interface decode_issue_queue_if #(
  parameter int ROB_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [31:0]      in_addr;

  logic [4:0]       reg_id1;
  logic [4:0]       reg_id2;
  logic [31:0]      reg_val1_in;
  logic [31:0]      reg_val2_in;
  logic             dep1_in;
  logic             dep2_in;
  logic [ROB_W-1:0] rob_id1_in;
  logic [ROB_W-1:0] rob_id2_in;
  logic [ROB_W-1:0] rd_rob_id_in;

  logic             issue_ready;
  logic             issue_valid;
  logic             issue_to_lsb;
  logic             issue_illegal;
  logic [31:0]      issue_instr;
  logic [31:0]      issue_addr;
  logic [2:0]       issue_op;
  logic [6:0]       issue_type;
  logic [4:0]       issue_rd;
  logic [31:0]      issue_imm;
  logic [31:0]      issue_val1;
  logic [31:0]      issue_val2;
  logic             issue_dep1;
  logic             issue_dep2;
  logic [ROB_W-1:0] issue_rob1;
  logic [ROB_W-1:0] issue_rob2;
  logic [ROB_W-1:0] issue_rd_rob;

  modport slave (
    input  in_valid, in_instr, in_addr,
    input  reg_val1_in, reg_val2_in, dep1_in, dep2_in,
    input  rob_id1_in, rob_id2_in, rd_rob_id_in, issue_ready,
    output in_ready, reg_id1, reg_id2,
    output issue_valid, issue_to_lsb, issue_illegal, issue_instr, issue_addr,
    output issue_op, issue_type, issue_rd, issue_imm, issue_val1, issue_val2,
    output issue_dep1, issue_dep2, issue_rob1, issue_rob2, issue_rd_rob
  );

  modport master (
    output in_valid, in_instr, in_addr,
    output reg_val1_in, reg_val2_in, dep1_in, dep2_in,
    output rob_id1_in, rob_id2_in, rd_rob_id_in, issue_ready,
    input  in_ready, reg_id1, reg_id2,
    input  issue_valid, issue_to_lsb, issue_illegal, issue_instr, issue_addr,
    input  issue_op, issue_type, issue_rd, issue_imm, issue_val1, issue_val2,
    input  issue_dep1, issue_dep2, issue_rob1, issue_rob2, issue_rd_rob
  );
endinterface

// File: rtl/decode_issue_queue_imm_gen.sv
// Combinational RV32I immediate extraction; unknown opcodes and OP yield zero.
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC:
        imm = {instr[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      OPC_JALR, OPC_LOAD, OPC_OP_IMM:
        imm = {{20{instr[31]}}, instr[31:20]};
      OPC_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_issue_queue.sv
// Buffered decode stage: predecodes fetched instructions into a DEPTH-entry FIFO and
// issues the head with register-file operands looked up combinationally each cycle.
module decode_issue_queue
  import decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ROB_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  decode_issue_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic             nonempty;
  logic             enq;
  logic             deq;

  entry_t           ent_p0;
  logic [31:0]      imm_p0;
  entry_t           mem_p1 [DEPTH];
  entry_t           head_p1;

  // Stage p0: predecode the incoming fetch word
  imm_gen u_imm_gen (
    .instr (bus.in_instr),
    .imm   (imm_p0)
  );

  always_comb begin
    ent_p0         = '0;
    ent_p0.instr   = bus.in_instr;
    ent_p0.addr    = bus.in_addr;
    ent_p0.imm     = imm_p0;
    ent_p0.opcode  = bus.in_instr[6:0];
    ent_p0.funct3  = bus.in_instr[14:12];
    ent_p0.rd      = has_rd(bus.in_instr[6:0])   ? bus.in_instr[11:7]  : 5'd0;
    ent_p0.rs1     = uses_rs1(bus.in_instr[6:0]) ? bus.in_instr[19:15] : 5'd0;
    ent_p0.rs2     = uses_rs2(bus.in_instr[6:0]) ? bus.in_instr[24:20] : 5'd0;
    ent_p0.to_lsb  = (bus.in_instr[6:0] == OPC_LOAD) || (bus.in_instr[6:0] == OPC_STORE);
    ent_p0.illegal = !is_legal(bus.in_instr[6:0]);
  end

  // Stage p1: queue storage and pointer control
  assign nonempty        = (count != '0);
  assign bus.in_ready    = (count < FULL_CNT);
  assign bus.issue_valid = nonempty && !flush;
  assign enq             = rdy && bus.in_valid && bus.in_ready && !flush;
  assign deq             = rdy && bus.issue_valid && bus.issue_ready;

  always_ff @(posedge clk) begin
    if (enq) mem_p1[tail] <= ent_p0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue side: an empty queue presents an all-zero entry
  always_comb begin
    head_p1 = '0;
    if (nonempty) head_p1 = mem_p1[head];
  end

  assign bus.reg_id1       = head_p1.rs1;
  assign bus.reg_id2       = head_p1.rs2;
  assign bus.issue_instr   = head_p1.instr;
  assign bus.issue_addr    = head_p1.addr;
  assign bus.issue_imm     = head_p1.imm;
  assign bus.issue_op      = head_p1.funct3;
  assign bus.issue_type    = head_p1.opcode;
  assign bus.issue_rd      = head_p1.rd;
  assign bus.issue_to_lsb  = head_p1.to_lsb;
  assign bus.issue_illegal = head_p1.illegal;
  assign bus.issue_rd_rob  = nonempty ? bus.rd_rob_id_in : '0;

  assign bus.issue_val1 = (head_p1.rs1 != 5'd0) ? bus.reg_val1_in : 32'd0;
  assign bus.issue_dep1 = (head_p1.rs1 != 5'd0) && bus.dep1_in;
  assign bus.issue_rob1 = (head_p1.rs1 != 5'd0) ? bus.rob_id1_in : '0;
  assign bus.issue_val2 = (head_p1.rs2 != 5'd0) ? bus.reg_val2_in : 32'd0;
  assign bus.issue_dep2 = (head_p1.rs2 != 5'd0) && bus.dep2_in;
  assign bus.issue_rob2 = (head_p1.rs2 != 5'd0) ? bus.rob_id2_in : '0;

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed + randomized bench for decode_issue_queue against a queue-based reference model.
module tb_decode_issue_queue;

  localparam int DEPTH = 4;
  localparam int ROB_W = 4;

  logic clk = 1'b0;
  logic rst, rdy, flush;

  decode_issue_queue_if #(.ROB_W(ROB_W)) bus ();

  decode_issue_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register file / scoreboard model answering the queue's combinational lookups
  logic [31:0]      regs [32];
  logic             pend [32];
  logic [ROB_W-1:0] tags [32];

  assign bus.reg_val1_in = regs[bus.reg_id1];
  assign bus.reg_val2_in = regs[bus.reg_id2];
  assign bus.dep1_in     = pend[bus.reg_id1];
  assign bus.dep2_in     = pend[bus.reg_id2];
  assign bus.rob_id1_in  = tags[bus.reg_id1];
  assign bus.rob_id2_in  = tags[bus.reg_id2];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } txn_t;

  txn_t q[$];
  int   total = 0;
  int   bad   = 0;

  logic [6:0] opc_tab [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                               7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1111011};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_legal(input logic [6:0] o);
    return o inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                     7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    int v;
    v = 0;
    case (i[6:0])
      7'b0110111, 7'b0010111: v = int'(i & 32'hFFFF_F000);
      7'b1101111: v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      7'b1100111, 7'b0000011, 7'b0010011: v = $signed(i[31:20]);
      7'b1100011: v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
      7'b0100011: v = $signed({i[31:25], i[11:7]});
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  task automatic check_outputs();
    logic [31:0] ins, addr;
    logic [6:0]  o;
    logic [4:0]  r1, r2, rd;
    bit          ne;
    ne = (q.size() != 0);
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
    chk("issue_valid", 32'(bus.issue_valid), 32'(ne && !flush));
    ins = 32'd0; addr = 32'd0; r1 = 5'd0; r2 = 5'd0; rd = 5'd0;
    if (ne) begin
      ins  = q[0].instr;
      addr = q[0].addr;
      o    = ins[6:0];
      r1   = (ref_legal(o) && !(o inside {7'b0110111, 7'b0010111, 7'b1101111})) ? ins[19:15] : 5'd0;
      r2   = (o inside {7'b0110011, 7'b0100011, 7'b1100011}) ? ins[24:20] : 5'd0;
      rd   = (o inside {7'b0100011, 7'b1100011}) ? 5'd0 : ins[11:7];
    end
    chk("issue_instr", bus.issue_instr, ins);
    chk("issue_addr", bus.issue_addr, addr);
    chk("issue_imm", bus.issue_imm, ref_imm(ins));
    chk("issue_type", 32'(bus.issue_type), 32'(ins[6:0]));
    chk("issue_op", 32'(bus.issue_op), 32'(ins[14:12]));
    chk("issue_rd", 32'(bus.issue_rd), 32'(rd));
    chk("reg_id1", 32'(bus.reg_id1), 32'(r1));
    chk("reg_id2", 32'(bus.reg_id2), 32'(r2));
    chk("issue_to_lsb", 32'(bus.issue_to_lsb),
        32'(ne && (ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0100011)));
    chk("issue_illegal", 32'(bus.issue_illegal), 32'(ne && !ref_legal(ins[6:0])));
    chk("issue_val1", bus.issue_val1, (r1 != 0) ? regs[r1] : 32'd0);
    chk("issue_val2", bus.issue_val2, (r2 != 0) ? regs[r2] : 32'd0);
    chk("issue_dep1", 32'(bus.issue_dep1), 32'((r1 != 0) && pend[r1]));
    chk("issue_dep2", 32'(bus.issue_dep2), 32'((r2 != 0) && pend[r2]));
    chk("issue_rob1", 32'(bus.issue_rob1), (r1 != 0) ? 32'(tags[r1]) : 32'd0);
    chk("issue_rob2", 32'(bus.issue_rob2), (r2 != 0) ? 32'(tags[r2]) : 32'd0);
    chk("issue_rd_rob", 32'(bus.issue_rd_rob), ne ? 32'(bus.rd_rob_id_in) : 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    r[6:0] = opc_tab[$urandom_range(0, 9)];
    return r;
  endfunction

  task automatic drive(input bit v, input bit ir, input bit r, input bit f);
    bus.in_valid     = v;
    bus.issue_ready  = ir;
    rdy              = r;
    flush            = f;
    bus.in_instr     = rand_instr();
    bus.in_addr      = $urandom & 32'hFFFF_FFFC;
    bus.rd_rob_id_in = ROB_W'($urandom);
    for (int k = 0; k < 32; k++) begin
      regs[k] = $urandom;
      pend[k] = 1'($urandom);
      tags[k] = ROB_W'($urandom);
    end
  endtask

  // Check current outputs, advance the model by one clock, land on the next falling edge
  task automatic step();
    int  n;
    bit  e, d;
    #1;
    check_outputs();
    n = q.size();
    e = rdy && bus.in_valid && (n < DEPTH);
    d = rdy && !flush && (n != 0) && bus.issue_ready;
    if (flush) q.delete();
    else begin
      if (d) void'(q.pop_front());
      if (e) q.push_back('{bus.in_instr, bus.in_addr});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 1, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step();

    // Fill with issue blocked: fifth offer must be refused
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 1, 0);
      step();
    end
    chk("fill_depth", 32'(q.size()), 32'(DEPTH));

    // Stream 8 instructions at full throughput, then drain
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 1, 0);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 1, 0);
      step();
    end

    // addi x1,x0,-1 followed by sw x1,0(x2)
    drive(1, 0, 1, 0);
    bus.in_instr = 32'hFFF0_0093;
    step();
    drive(1, 0, 1, 0);
    bus.in_instr = 32'h0011_2023;
    #1;
    chk("addi_imm", bus.issue_imm, 32'hFFFF_FFFF);
    chk("addi_val1", bus.issue_val1, 32'd0);
    chk("addi_dep2", 32'(bus.issue_dep2), 32'd0);
    step();
    drive(0, 1, 1, 0);
    step();
    chk("sw_to_lsb", 32'(bus.issue_to_lsb), 32'd1);
    chk("sw_rd", 32'(bus.issue_rd), 32'd0);
    step();

    // Flush beats enqueue and dequeue in the same cycle
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1, 0);
      step();
    end
    drive(1, 1, 1, 1);
    step();
    drive(0, 0, 1, 0);
    #1;
    chk("flush_valid", 32'(bus.issue_valid), 32'd0);
    chk("flush_ready", 32'(bus.in_ready), 32'd1);
    step();

    // rdy low holds everything
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1, 0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 0);
      step();
    end

    // Asynchronous reset with three entries queued
    drive(0, 1, 1, 0);
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0);
      step();
    end
    drive(0, 0, 1, 0);
    rst = 1'b1;
    #1;
    q.delete();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 24) == 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
